// File: rtl/psa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : psa_pkg                                                       |
// | Purpose  : Shared constants and types for the nibble-serial partitioned  |
// |            sub-word add (PSA) sequencer.                                 |
// | Contents : lane geometry, sequencer state enum, requester id type.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package psa_pkg;

  localparam int PSA_LANE_W = 4;
  localparam int PSA_LANES  = 4;
  localparam int PSA_WORD_W = PSA_LANE_W * PSA_LANES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage : psa_pkg
`default_nettype wire

// File: rtl/psa_lane_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : psa_lane_add                                                  |
// | Purpose  : Combinational single-lane signed add (modulo 2^LANE_W) with   |
// |            two's-complement overflow detection.                          |
// | Ports    : i_a, i_b  - lane operands                                     |
// |            o_s       - lane sum, carry out discarded                     |
// |            o_ovfl    - signed overflow of this lane                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module psa_lane_add
  import psa_pkg::*;
(
  input  logic [PSA_LANE_W-1:0] i_a,
  input  logic [PSA_LANE_W-1:0] i_b,
  output logic [PSA_LANE_W-1:0] o_s,
  output logic                  o_ovfl
);

  always_comb begin
    o_s    = i_a + i_b;
    // Overflow only when both operands share a sign and the result flips it.
    o_ovfl = (i_a[PSA_LANE_W-1] == i_b[PSA_LANE_W-1]) &&
             (o_s[PSA_LANE_W-1] != i_a[PSA_LANE_W-1]);
  end

endmodule : psa_lane_add
`default_nettype wire

// File: rtl/psa_rr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : psa_rr_sequencer                                              |
// | Purpose  : Two requesters share one 4-bit lane adder. Each accepted      |
// |            16-bit PSA operation is executed one lane per cycle, then     |
// |            held in DONE until the consumer takes it.                     |
// | Ports    : clk, rst_n            - clock, async active-low reset         |
// |            reqN_valid/ready/a/b  - issue ports, N = 0,1                  |
// |            rsp_valid/ready       - result handshake                      |
// |            rsp_id/sum/ovfl/error - result payload                        |
// |            busy                  - sequencer not idle                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module psa_rr_sequencer
  import psa_pkg::*;
#(
  parameter int LANE_W   = 4,
  parameter int LANES    = 4,
  parameter bit RR_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [LANE_W*LANES-1:0]   req0_a,
  input  logic [LANE_W*LANES-1:0]   req0_b,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [LANE_W*LANES-1:0]   req1_a,
  input  logic [LANE_W*LANES-1:0]   req1_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [LANE_W*LANES-1:0]   rsp_sum,
  output logic [LANES-1:0]          rsp_ovfl,
  output logic                      rsp_error,
  output logic                      busy
);

  localparam int W = LANE_W * LANES;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  req_id_t           id_q, id_d;
  req_id_t           last_q, last_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [LANES-1:0]  ovfl_q, ovfl_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              grant_any;
  req_id_t           grant_id;
  logic              accept;
  logic [3:0]        lane_base;
  logic [LANE_W-1:0] lane_a, lane_b, lane_s;
  logic              lane_ovfl;

  // Round-robin pick: a lone requester always wins; on contention the one
  // that did not win last time gets the grant.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    accept    = (state_q == ST_IDLE) & grant_any;
  end

  // Single shared adder, fed by a lane-select mux on the counter.
  always_comb begin
    lane_base = {cnt_q, 2'b00};
    lane_a    = a_q[lane_base +: LANE_W];
    lane_b    = b_q[lane_base +: LANE_W];
  end

  psa_lane_add u_lane_add (
    .i_a    (lane_a),
    .i_b    (lane_b),
    .o_s    (lane_s),
    .o_ovfl (lane_ovfl)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= ~RR_FIRST;
      sum_q       <= '0;
      ovfl_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      ovfl_q      <= ovfl_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    last_d  = last_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          cnt_d   = 2'd0;
          sum_d   = '0;
          ovfl_d  = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        sum_d[lane_base +: LANE_W] = lane_s;
        ovfl_d[cnt_q]              = lane_ovfl;
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rsp_valid_d = (state_d == ST_DONE);
  end

  // Outputs.
  always_comb begin
    req0_ready = accept & (grant_id == 1'b0);
    req1_ready = accept & (grant_id == 1'b1);
    rsp_valid  = rsp_valid_q;
    rsp_id     = id_q;
    rsp_sum    = sum_q;
    rsp_ovfl   = ovfl_q;
    rsp_error  = |ovfl_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule : psa_rr_sequencer
`default_nettype wire

// File: tb/tb_psa_rr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_psa_rr_sequencer                                           |
// | Purpose  : Self-checking bench for psa_rr_sequencer: directed scenarios  |
// |            plus randomized traffic against a transaction-level model.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_psa_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_error, busy;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_sum;
  logic [3:0]  rsp_ovfl;

  always #5 clk = ~clk;

  psa_rr_sequencer #(.LANE_W(4), .LANES(4), .RR_FIRST(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_ovfl   (rsp_ovfl),
    .rsp_error  (rsp_error),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: an operation occupies the unit from its accept
  // edge; the result is visible once four lane cycles have elapsed and is
  // retired by the first rsp_ready seen while it is visible.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [15:0] m_sum;
  logic [3:0]  m_ovfl;
  int          grant_log[$];

  function automatic logic [19:0] ref_psa(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  o;
    s = '0;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      int na, nb, r;
      na = int'((a >> (4 * i)) & 16'hF);
      nb = int'((b >> (4 * i)) & 16'hF);
      if (na >= 8) na = na - 16;
      if (nb >= 8) nb = nb - 16;
      r = na + nb;
      s = s | (16'(r & 15) << (4 * i));
      o[i] = (r > 7) || (r < -8);
    end
    return {o, s};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
    m_id   = 1'b0;
  endtask

  // One clock cycle: drive, check, advance the model, move to next negedge.
  task automatic step(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                      input bit v1, input logic [15:0] a1, input logic [15:0] b1,
                      input bit rr);
    bit e0, e1, ev;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      e0 = v0 && (!v1 || m_last);
      e1 = v1 && (!v0 || !m_last);
    end
    ev = m_busy && (m_age >= 4);
    check_value("req0_ready", req0_ready, e0);
    check_value("req1_ready", req1_ready, e1);
    check_value("busy", busy, m_busy);
    check_value("rsp_valid", rsp_valid, ev);
    if (ev) begin
      check_value("rsp_sum", rsp_sum, m_sum);
      check_value("rsp_ovfl", rsp_ovfl, m_ovfl);
      check_value("rsp_error", rsp_error, m_ovfl != 4'd0);
      check_value("rsp_id", rsp_id, m_id);
    end
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);
    if (m_busy) begin
      if (ev && rr) m_busy = 1'b0;
      else m_age++;
    end else if (e0 || e1) begin
      m_busy = 1'b1;
      m_age  = 0;
      m_id   = e1;
      m_last = e1;
      {m_ovfl, m_sum} = ref_psa(e1 ? a1 : a0, e1 ? b1 : b0);
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n, input bit rr);
    repeat (n) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, rr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check_value("reset_rsp_valid", rsp_valid, 0);
    check_value("reset_sum", rsp_sum, 0);
    check_value("reset_ovfl", rsp_ovfl, 0);
    check_value("reset_busy", busy, 0);

    // Basic add, no overflow.
    step(1'b1, 16'h1234, 16'h1111, 1'b0, 16'h0, 16'h0, 1'b1);
    idle_steps(4, 1'b1);
    check_value("t1_sum", rsp_sum, 16'h2345);
    check_value("t1_ovfl", rsp_ovfl, 4'b0000);
    check_value("t1_id", rsp_id, 0);
    idle_steps(1, 1'b1);

    // Requester 1, overflow in lane 3.
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h7000, 16'h1000, 1'b0);
    idle_steps(4, 1'b0);
    check_value("t2_sum", rsp_sum, 16'h8000);
    check_value("t2_ovfl", rsp_ovfl, 4'b1000);
    check_value("t2_err", rsp_error, 1);
    check_value("t2_id", rsp_id, 1);
    idle_steps(1, 1'b1);

    // Lane 0 overflow, carry must not leak into lane 1.
    step(1'b1, 16'h0008, 16'h0008, 1'b0, 16'h0, 16'h0, 1'b0);
    idle_steps(4, 1'b0);
    check_value("t3_sum", rsp_sum, 16'h0000);
    check_value("t3_ovfl", rsp_ovfl, 4'b0001);
    // Hold the result with both requesters pushing; model checks stability.
    repeat (10) step(1'b1, 16'hFFFF, 16'h1234, 1'b1, 16'h5555, 16'hAAAA, 1'b0);
    check_value("hold_sum", rsp_sum, 16'h0000);
    idle_steps(1, 1'b1);
    idle_steps(1, 1'b0);

    // Contention from reset: strict alternation starting with requester 0.
    do_reset();
    grant_log.delete();
    repeat (18) step(1'b1, 16'($urandom), 16'($urandom),
                     1'b1, 16'($urandom), 16'($urandom), 1'b1);
    check_value("alt_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check_value("alt_g0", grant_log[0], 0);
      check_value("alt_g1", grant_log[1], 1);
      check_value("alt_g2", grant_log[2], 0);
    end

    // Reset during CALC with lane counter at 2.
    do_reset();
    step(1'b1, 16'h4321, 16'h1357, 1'b0, 16'h0, 16'h0, 1'b0);
    idle_steps(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_valid", rsp_valid, 0);
    check_value("mid_rst_sum", rsp_sum, 0);
    check_value("mid_rst_ovfl", rsp_ovfl, 0);
    check_value("mid_rst_err", rsp_error, 0);
    check_value("mid_rst_id", rsp_id, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(10, 1'b1);

    // Randomized traffic.
    repeat (600) begin
      step(($urandom_range(0, 99) < 40), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 40), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_psa_rr_sequencer
`default_nettype wire
